// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM encodings, the nop word and the reset vector.
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IFS_IDLE = 2'd0,
        IFS_REQ  = 2'd1,
        IFS_WAIT = 2'd2
    } ifs_state_t;

    localparam logic [31:0] IFETCH_NOP   = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction bus: master issues the address, slave accepts it and returns data.
interface inst_fetch_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready holding register between fetch and decode.
module fetch_out_buf #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          drain,
    input  logic          flush,
    input  logic [DW-1:0] load_instr,
    input  logic [AW-1:0] load_pc,
    input  logic          load_adel,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc,
    output logic          adel,
    output logic          valid
);

    // flush beats load, load beats drain so a same-cycle refill keeps valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            adel  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
            adel  <= load_adel;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller: one instruction-bus transaction per PC, result held for decode.
// Optional IFETCH_ADEL_EN: misaligned PCs skip the bus and deliver a nop tagged with adel_o.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       pc_i,
    input  logic                fetch_en_i,
    input  logic                flush_i,
    output logic                pc_adv_o,
    inst_fetch_ctrl_if.master   bus,
    output logic [DW-1:0]       instr_o,
    output logic [AW-1:0]       instr_pc_o,
    output logic                instr_valid_o,
    input  logic                out_ready_i,
    output logic                adel_o
);

    ifs_state_t    state, state_nxt;
    logic          cancel, cancel_nxt;
    logic [AW-1:0] req_pc;
    logic          capture;
    logic          launch;
    logic          misaligned;
    logic          buf_load;
    logic [DW-1:0] buf_instr;
    logic [AW-1:0] buf_pc;
    logic          buf_adel;

    assign launch = fetch_en_i & ~flush_i & (~instr_valid_o | out_ready_i);

`ifdef IFETCH_ADEL_EN
    assign misaligned = |pc_i[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // the address is held from launch so a redirect cannot disturb a pending request
    assign bus.inst_addr = {req_pc[AW-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IFS_IDLE;
            cancel <= 1'b0;
            req_pc <= '0;
        end else begin
            state  <= state_nxt;
            cancel <= cancel_nxt;
            if (capture) req_pc <= pc_i;
        end
    end

    always_comb begin
        state_nxt    = state;
        cancel_nxt   = cancel;
        capture      = 1'b0;
        bus.inst_req = 1'b0;
        pc_adv_o     = 1'b0;
        buf_load     = 1'b0;
        buf_instr    = bus.inst_rdata;
        buf_pc       = req_pc;
        buf_adel     = 1'b0;
        case (state)
            IFS_IDLE: begin
                if (launch) begin
                    if (misaligned) begin
                        buf_load  = 1'b1;
                        buf_instr = DW'(IFETCH_NOP);
                        buf_pc    = pc_i;
                        buf_adel  = 1'b1;
                        pc_adv_o  = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = IFS_REQ;
                    end
                end
            end
            IFS_REQ: begin
                bus.inst_req = 1'b1;
                if (flush_i) cancel_nxt = 1'b1;
                if (bus.inst_addr_ok) state_nxt = IFS_WAIT;
            end
            IFS_WAIT: begin
                if (bus.inst_data_ok) begin
                    state_nxt  = IFS_IDLE;
                    cancel_nxt = 1'b0;
                    if (!cancel && !flush_i) begin
                        buf_load = 1'b1;
                        pc_adv_o = 1'b1;
                    end
                end else if (flush_i) begin
                    cancel_nxt = 1'b1;
                end
            end
            default: state_nxt = IFS_IDLE;
        endcase
    end

    fetch_out_buf #(.AW(AW), .DW(DW)) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .drain      (out_ready_i),
        .flush      (flush_i),
        .load_instr (buf_instr),
        .load_pc    (buf_pc),
        .load_adel  (buf_adel),
        .instr      (instr_o),
        .pc         (instr_pc_o),
        .adel       (adel_o),
        .valid      (instr_valid_o)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a small PC model and hand-computed expectations.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_q;
    logic        fetch_en = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_tgt = 32'h0;
    logic        pc_adv;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        out_ready = 1'b1;
    logic        adel;
    int          n_cmp = 0;
    int          n_err = 0;
    int          adv_cnt = 0;
    int          base;
    logic        outst;
    logic [31:0] addr_s;
    logic        adv_s;

    inst_fetch_ctrl_if #(.AW(32), .DW(32)) bus ();

    inst_fetch_ctrl #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_q),
        .fetch_en_i    (fetch_en),
        .flush_i       (flush),
        .pc_adv_o      (pc_adv),
        .bus           (bus),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .out_ready_i   (out_ready),
        .adel_o        (adel)
    );

    always #5 clk = ~clk;

    // PC register the controller drives: redirect wins over advance
    always @(posedge clk or posedge rst) begin
        if (rst)         pc_q <= RESET_VECTOR;
        else if (flush)  pc_q <= flush_tgt;
        else if (pc_adv) pc_q <= pc_q + 32'd4;
    end

    always @(posedge clk) if (pc_adv) adv_cnt <= adv_cnt + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) outst <= 1'b0;
        else if (bus.inst_req && bus.inst_addr_ok) outst <= 1'b1;
        else if (bus.inst_data_ok) outst <= 1'b0;
    end

    ap_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.inst_req && !bus.inst_addr_ok) |=> $stable(bus.inst_addr));
    ap_one_outstanding: assert property (@(posedge clk) disable iff (rst)
        (bus.inst_req && bus.inst_addr_ok) |-> !outst);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // waits for a request, accepts it after aok_wait cycles, answers after dok_wait more
    task automatic run_fetch(input logic [31:0] rdata, input int aok_wait, input int dok_wait,
                             output logic [31:0] addr, output logic adv);
        int n = 0;
        while (!bus.inst_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'b0, bus.inst_req}, 32'd1);
        addr = bus.inst_addr;
        repeat (aok_wait) tick();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        repeat (dok_wait) tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = rdata;
        #1 adv = pc_adv;
        tick();
        bus.inst_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        #3;
        chk("rst_req", {31'b0, bus.inst_req}, 32'd0);
        chk("rst_adv", {31'b0, pc_adv}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_adel", {31'b0, adel}, 32'd0);
        @(posedge clk);
        tick();
        rst = 1'b0;

        // 1: first fetch from the reset vector
        run_fetch(32'h3c080001, 0, 0, addr_s, adv_s);
        chk("t1_addr", addr_s, 32'hbfc00000);
        chk("t1_adv", {31'b0, adv_s}, 32'd1);
        chk("t1_instr", instr, 32'h3c080001);
        chk("t1_ipc", instr_pc, 32'hbfc00000);
        chk("t1_valid", {31'b0, instr_valid}, 32'd1);
        chk("t1_adel", {31'b0, adel}, 32'd0);
        chk("t1_advcnt", adv_cnt, 32'd1);

        // 2: back-to-back, then decode stalls
        tick();
        out_ready = 1'b0;
        chk("t2_req", {31'b0, bus.inst_req}, 32'd1);
        run_fetch(32'h24090002, 1, 2, addr_s, adv_s);
        chk("t2_addr", addr_s, 32'hbfc00004);
        chk("t2_adv", {31'b0, adv_s}, 32'd1);
        chk("t2_instr", instr, 32'h24090002);
        chk("t2_ipc", instr_pc, 32'hbfc00004);
        base = adv_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_stall_req", {31'b0, bus.inst_req}, 32'd0);
        end
        chk("t2_stall_adv", adv_cnt, base);
        chk("t2_hold_instr", instr, 32'h24090002);
        chk("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t2_resume_req", {31'b0, bus.inst_req}, 32'd1);
        chk("t2_resume_addr", bus.inst_addr, 32'hbfc00008);
        run_fetch(32'h8c0a0000, 0, 0, addr_s, adv_s);
        chk("t2_ipc3", instr_pc, 32'hbfc00008);

        // flush in IDLE clears the held entry
        out_ready = 1'b0;
        flush = 1'b1;
        flush_tgt = 32'hbfc00100;
        base = adv_cnt;
        #1 chk("idle_flush_adv", {31'b0, pc_adv}, 32'd0);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("idle_flush_valid", {31'b0, instr_valid}, 32'd0);
        chk("idle_flush_advcnt", adv_cnt, base);

        // 3: flush while waiting, data 4 cycles later
        tick();
        chk("t3_addr", bus.inst_addr, 32'hbfc00100);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        flush = 1'b1;
        flush_tgt = 32'hbfc00380;
        base = adv_cnt;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_wait_req", {31'b0, bus.inst_req}, 32'd0);
        end
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'hdeadbeef;
        #1 chk("t3_drop_adv", {31'b0, pc_adv}, 32'd0);
        tick();
        bus.inst_data_ok = 1'b0;
        chk("t3_valid", {31'b0, instr_valid}, 32'd0);
        chk("t3_advcnt", adv_cnt, base);
        tick();
        chk("t3_new_req", {31'b0, bus.inst_req}, 32'd1);
        chk("t3_new_addr", bus.inst_addr, 32'hbfc00380);
        run_fetch(32'h34020003, 0, 0, addr_s, adv_s);
        chk("t3_instr", instr, 32'h34020003);
        chk("t3_ipc", instr_pc, 32'hbfc00380);

        // 4a: flush together with data_ok
        tick();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h11111111;
        flush = 1'b1;
        flush_tgt = 32'hbfc00500;
        base = adv_cnt;
        #1 chk("t4a_adv", {31'b0, pc_adv}, 32'd0);
        tick();
        bus.inst_data_ok = 1'b0;
        flush = 1'b0;
        chk("t4a_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4a_advcnt", adv_cnt, base);
        tick();
        chk("t4a_addr", bus.inst_addr, 32'hbfc00500);

        // 4b: flush while addr_ok is stalled
        flush = 1'b1;
        flush_tgt = 32'hbfc00600;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4b_req", {31'b0, bus.inst_req}, 32'd1);
            chk("t4b_addr", bus.inst_addr, 32'hbfc00500);
            tick();
        end
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h22222222;
        #1 chk("t4b_adv", {31'b0, pc_adv}, 32'd0);
        tick();
        bus.inst_data_ok = 1'b0;
        chk("t4b_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4b_advcnt", adv_cnt, base);
        tick();
        chk("t4b_new_addr", bus.inst_addr, 32'hbfc00600);
        run_fetch(32'h3c1d8000, 0, 0, addr_s, adv_s);
        chk("t4b_instr", instr, 32'h3c1d8000);
        chk("t4b_ipc", instr_pc, 32'hbfc00600);

        // 5: reset in WAIT, late data_ok ignored
        tick();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_req", {31'b0, bus.inst_req}, 32'd0);
        chk("t5_valid", {31'b0, instr_valid}, 32'd0);
        chk("t5_instr", instr, 32'h0);
        chk("t5_ipc", instr_pc, 32'h0);
        tick();
        rst = 1'b0;
        fetch_en = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h99999999;
        base = adv_cnt;
        #1 chk("t5_late_adv", {31'b0, pc_adv}, 32'd0);
        tick();
        bus.inst_data_ok = 1'b0;
        chk("t5_late_valid", {31'b0, instr_valid}, 32'd0);
        chk("t5_late_advcnt", adv_cnt, base);
        chk("t5_idle_req", {31'b0, bus.inst_req}, 32'd0);
        fetch_en = 1'b1;
        tick();
        chk("t5_restart_addr", bus.inst_addr, 32'hbfc00000);
        run_fetch(32'haabbccdd, 0, 1, addr_s, adv_s);
        chk("t5_instr", instr, 32'haabbccdd);
        chk("t5_ipc2", instr_pc, 32'hbfc00000);

        // 6: misaligned PC
        flush = 1'b1;
        flush_tgt = 32'hbfc00002;
        tick();
        flush = 1'b0;
`ifdef IFETCH_ADEL_EN
        chk("t6_req", {31'b0, bus.inst_req}, 32'd0);
        #1 chk("t6_adv", {31'b0, pc_adv}, 32'd1);
        tick();
        chk("t6_instr", instr, 32'h0);
        chk("t6_adel", {31'b0, adel}, 32'd1);
        chk("t6_ipc", instr_pc, 32'hbfc00002);
        chk("t6_req2", {31'b0, bus.inst_req}, 32'd0);
        tick();
        chk("t6_reload_valid", {31'b0, instr_valid}, 32'd1);
        chk("t6_reload_ipc", instr_pc, 32'hbfc00006);
        fetch_en = 1'b0;
        tick();
`else
        tick();
        chk("t6_req", {31'b0, bus.inst_req}, 32'd1);
        chk("t6_addr", bus.inst_addr, 32'hbfc00000);
        run_fetch(32'h55aa55aa, 0, 0, addr_s, adv_s);
        chk("t6_instr", instr, 32'h55aa55aa);
        chk("t6_ipc", instr_pc, 32'hbfc00002);
        chk("t6_adel", {31'b0, adel}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
